imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 Parameter XLEN, default 32, requester address width in bits.
REQ-002 Parameter ADDR_W, default 10, memory word-address width (1024 words).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 f_req  input  1  fetch read request.
REQ-006 f_addr  input  XLEN  fetch byte address.
REQ-007 f_gnt  output  1  fetch request accepted this cycle.
REQ-008 f_rvalid  output  1  rdata carries fetch read data.
REQ-009 l_req  input  1  loader request (program load / debug).
REQ-010 l_lock  input  1  loader holds exclusive ownership across a burst.
REQ-011 l_we  input  1  loader write (1) or read (0).
REQ-012 l_addr  input  XLEN  loader byte address.
REQ-013 l_wdata  input  32  loader write data.
REQ-014 l_gnt  output  1  loader request accepted this cycle.
REQ-015 l_rvalid  output  1  rdata carries loader read data.
REQ-016 rdata  output  32  shared read-data return, equals mem_rdata.
REQ-017 mem_en, mem_we  output  1 each  memory command strobe and write enable.
REQ-018 mem_addr  output  ADDR_W  word address; mem_wdata output 32; mem_rdata input 32 (valid one cycle after mem_en).
REQ-019 f_stall_cnt  output  32  cycles with f_req=1 and f_gnt=0.

Function
REQ-020 Grants combinational from current req and state; f_gnt and l_gnt never both 1; mem_en = f_gnt | l_gnt.
REQ-021 Granted command driven to memory in grant cycle: mem_addr = addr[ADDR_W+1:2]; bits [1:0] and above ADDR_W+1 ignored (address wraps modulo memory size).
REQ-022 mem_we = l_gnt & l_we; fetch never writes; mem_wdata = l_wdata.
REQ-023 Single requester: granted same cycle (zero-wait).
REQ-024 Both requesting, state ARB_IDLE: round-robin; winner is the requester not granted most recently; last-winner register updates only on a grant.
REQ-025 States ARB_IDLE, ARB_LOCKED. IDLE->LOCKED on edge where l_gnt=1 and l_lock=1. LOCKED->IDLE on edge where l_lock=0.
REQ-026 In ARB_LOCKED f_gnt=0; l_gnt=l_req.
REQ-027 Read return: exactly one cycle after a read grant, matching rvalid (f_rvalid or l_rvalid) = 1 for one cycle; writes produce no rvalid.
REQ-028 Back-to-back reads: one grant per cycle, rvalid pipelined in order, no bubbles.
REQ-029 Requester not granted holds req/addr/data stable; arbiter stores no requests.
REQ-030 Fairness: without lock, both requesting continuously, each granted at least every 2 cycles.
REQ-031 f_stall_cnt increments each cycle f_req & ~f_gnt; saturates at 32'hFFFF_FFFF.

Reset
REQ-032 While reset=1: f_gnt=l_gnt=mem_en=mem_we=0; on edge: state ARB_IDLE, last winner = loader (fetch wins first tie), f_rvalid=l_rvalid=0, f_stall_cnt=0.
REQ-033 Reset during outstanding read cancels return: no rvalid in cycle after reset edge.

Structure
REQ-034 Shared package core_pkg holds arb_state_t {ARB_IDLE, ARB_LOCKED}, requester-id enum {REQ_FETCH, REQ_LOAD}, default IMEM_ADDR_W=10.
REQ-035 One sub-module rr_arbiter2: 2-way round-robin pointer with grant-enable input; lock FSM, return tagging, counter stay in imem_arbiter.

Verification
REQ-036 f_req=1 f_addr=0x10 alone -> f_gnt same cycle, mem_addr=4, next cycle f_rvalid=1, rdata=mem[4].
REQ-037 Both req continuous, no lock, from reset -> grants F,L,F,L...; f_stall_cnt +1 per loader grant.
REQ-038 l_req=l_lock=l_we=1, writes 0xDEADBEEF..+3 to 0x0..0xC, f_req=1 -> 4 l_gnt cycles, f_gnt=0, no rvalid; fetch granted cycle after l_lock=0.
REQ-039 l_addr=0x1004 (ADDR_W=10) write 0xA5A5A5A5 -> mem_addr=1; fetch 0x4 returns 0xA5A5A5A5.
REQ-040 Fetch read granted, reset=1 next cycle -> f_rvalid=0, grants 0, state ARB_IDLE, f_stall_cnt=0.
REQ-041 Stall counter preloaded via force to 0xFFFFFFFE, fetch blocked 3 cycles -> holds 0xFFFFFFFF.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the instruction-memory arbiter and its round-robin core.
package core_pkg;

  // Default instruction memory depth: 1024 32-bit words.
  localparam int IMEM_ADDR_W = 10;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  // Requester ids double as bit positions in the 2-bit request/grant vectors.
  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_LOAD  = 1'b1
  } req_id_t;

  // Saturating 32-bit increment for event counters that must never wrap.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/imem_arbiter_if.sv
// Bus bundle between the fetch unit, the program loader, the arbiter and the
// single-port instruction memory. The arbiter takes the slave view.
interface imem_arbiter_if
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = IMEM_ADDR_W
);

  // fetch requester
  logic              f_req;
  logic [XLEN-1:0]   f_addr;
  logic              f_gnt;
  logic              f_rvalid;

  // loader requester
  logic              l_req;
  logic              l_lock;
  logic              l_we;
  logic [XLEN-1:0]   l_addr;
  logic [31:0]       l_wdata;
  logic              l_gnt;
  logic              l_rvalid;

  // shared read return
  logic [31:0]       rdata;

  // memory port
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  // status
  logic [31:0]       f_stall_cnt;

  modport slave (
    input  f_req, f_addr,
    input  l_req, l_lock, l_we, l_addr, l_wdata,
    input  mem_rdata,
    output f_gnt, f_rvalid,
    output l_gnt, l_rvalid,
    output rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    output f_stall_cnt
  );

  modport master (
    output f_req, f_addr,
    output l_req, l_lock, l_we, l_addr, l_wdata,
    output mem_rdata,
    input  f_gnt, f_rvalid,
    input  l_gnt, l_rvalid,
    input  rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    input  f_stall_cnt
  );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter. Grants are combinational; the last-winner
// pointer follows whatever grant the parent finally issued (upd_vld/upd_id),
// so grants made outside this block (e.g. during a lock) still count.
module rr_arbiter2
  import core_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       gnt_en,
  input  logic       upd_vld,
  input  req_id_t    upd_id,
  output logic [1:0] gnt
);

  req_id_t last_q, last_d;

  // Grant the lone requester, or on a tie the one that did not win last.
  always_comb begin
    gnt = 2'b00;
    if (gnt_en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == REQ_LOAD) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Pointer only moves when a grant is actually issued.
  always_comb begin
    last_d = last_q;
    if (upd_vld) last_d = upd_id;
  end

  // Loader is the reset "last winner" so fetch takes the first tie.
  always_ff @(posedge clk) begin
    if (reset) last_q <= REQ_LOAD;
    else       last_q <= last_d;
  end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction-memory arbiter: shares one single-port memory between the
// instruction fetch path and a program/debug loader.
//
//   state      | meaning
//   -----------+--------------------------------------------------------
//   ARB_IDLE   | round-robin between fetch and loader
//   ARB_LOCKED | loader owns the memory; fetch is held off until l_lock=0
//
// Read data comes back one cycle after the grant; the rvalid tag flops
// remember which requester it belongs to. No requests are queued here:
// an ungranted requester simply keeps its request up.
module imem_arbiter
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = IMEM_ADDR_W
) (
  input  logic clk,
  input  logic reset,
  imem_arbiter_if.slave bus
);

  arb_state_t  state_q, state_d;

  logic [1:0]  rr_req;
  logic [1:0]  rr_gnt;
  logic        rr_en;
  logic        f_gnt;
  logic        l_gnt;
  logic        upd_vld;
  req_id_t     upd_id;

  logic        f_rvalid_q, f_rvalid_d;
  logic        l_rvalid_q, l_rvalid_d;
  logic [31:0] f_stall_cnt_q, f_stall_cnt_d;

  // Only the word-index bits of each byte address reach the memory.
  logic        unused_addr_bits;
  assign unused_addr_bits = ^{bus.f_addr[1:0], bus.f_addr[XLEN-1:ADDR_W+2],
                              bus.l_addr[1:0], bus.l_addr[XLEN-1:ADDR_W+2]};

  assign rr_req = {bus.l_req, bus.f_req};

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .req     (rr_req),
    .gnt_en  (rr_en),
    .upd_vld (upd_vld),
    .upd_id  (upd_id),
    .gnt     (rr_gnt)
  );

  // Final grants: round-robin when idle, loader-only while locked, none in reset.
  always_comb begin
    rr_en = 1'b0;
    f_gnt = 1'b0;
    l_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        ARB_IDLE: begin
          rr_en = 1'b1;
          f_gnt = rr_gnt[REQ_FETCH];
          l_gnt = rr_gnt[REQ_LOAD];
        end
        ARB_LOCKED: begin
          l_gnt = bus.l_req;
        end
        default: begin
          f_gnt = 1'b0;
          l_gnt = 1'b0;
        end
      endcase
    end
  end

  // Report the issued grant back to the round-robin pointer.
  always_comb begin
    upd_vld = f_gnt | l_gnt;
    upd_id  = l_gnt ? REQ_LOAD : REQ_FETCH;
  end

  // Lock FSM: a granted locked loader access takes ownership; dropping l_lock frees it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB_IDLE:   if (l_gnt && bus.l_lock) state_d = ARB_LOCKED;
      ARB_LOCKED: if (!bus.l_lock)         state_d = ARB_IDLE;
      default:                             state_d = ARB_IDLE;
    endcase
  end

  // Return tagging and fetch stall accounting.
  always_comb begin
    f_rvalid_d    = f_gnt;
    l_rvalid_d    = l_gnt & ~bus.l_we;
    f_stall_cnt_d = f_stall_cnt_q;
    if (bus.f_req && !f_gnt) f_stall_cnt_d = sat_inc32(f_stall_cnt_q);
  end

  // State, return tags and counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ARB_IDLE;
      f_rvalid_q    <= 1'b0;
      l_rvalid_q    <= 1'b0;
      f_stall_cnt_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      f_rvalid_q    <= f_rvalid_d;
      l_rvalid_q    <= l_rvalid_d;
      f_stall_cnt_q <= f_stall_cnt_d;
    end
  end

  // Memory command follows the grant in the same cycle.
  always_comb begin
    bus.f_gnt     = f_gnt;
    bus.l_gnt     = l_gnt;
    bus.mem_en    = f_gnt | l_gnt;
    bus.mem_we    = l_gnt & bus.l_we;
    bus.mem_addr  = l_gnt ? bus.l_addr[ADDR_W+1:2] : bus.f_addr[ADDR_W+1:2];
    bus.mem_wdata = bus.l_wdata;
  end

  // Read return; an outstanding return is dropped as soon as reset is raised.
  always_comb begin
    bus.rdata       = bus.mem_rdata;
    bus.f_rvalid    = f_rvalid_q & ~reset;
    bus.l_rvalid    = l_rvalid_q & ~reset;
    bus.f_stall_cnt = f_stall_cnt_q;
  end

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural memory and a read-return
// scoreboard checked by an independent monitor.
module tb_imem_arbiter;
  import core_pkg::*;

  typedef struct packed {
    logic        is_f;
    logic [31:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  int n_pass  = 0;
  int n_total = 0;

  exp_t exp_q[$];
  logic [31:0] mem [0:1023];

  imem_arbiter_if #(.XLEN(32), .ADDR_W(10)) bus ();

  imem_arbiter #(.XLEN(32), .ADDR_W(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  // Single-port memory with one-cycle read latency.
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else            bus.mem_rdata     <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic push(input logic is_f, input logic [31:0] data);
    exp_t e;
    e.is_f = is_f;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic drv(input logic fr, input logic [31:0] fa, input logic lr,
                     input logic lk, input logic lw, input logic [31:0] la,
                     input logic [31:0] ld);
    bus.f_req   = fr;
    bus.f_addr  = fa;
    bus.l_req   = lr;
    bus.l_lock  = lk;
    bus.l_we    = lw;
    bus.l_addr  = la;
    bus.l_wdata = ld;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  // Monitor: every read return must match the oldest expected entry.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (bus.f_rvalid === 1'b1 && bus.l_rvalid === 1'b1) begin
      n_total++;
      $display("FAIL rvalid_both: got f=1 l=1 expected at most one");
    end else if (bus.f_rvalid === 1'b1 || bus.l_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rvalid: got f=%0b l=%0b rdata=%08h expected none",
                 bus.f_rvalid, bus.l_rvalid, bus.rdata);
      end else begin
        e = exp_q.pop_front();
        chk("rv_tag", {31'd0, bus.f_rvalid}, {31'd0, e.is_f});
        chk("rv_data", bus.rdata, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 + i;
    bus.mem_rdata = 32'd0;

    // Reset: everything quiet even with both requesting and a write pending.
    reset = 1'b1;
    drv(1, 32'h10, 1, 1, 1, 32'h20, 32'h1234);
    step();
    #1;
    chk("rst_f_gnt", {31'd0, bus.f_gnt}, 32'd0);
    chk("rst_l_gnt", {31'd0, bus.l_gnt}, 32'd0);
    chk("rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_f_rvalid", {31'd0, bus.f_rvalid}, 32'd0);
    chk("rst_stall", bus.f_stall_cnt, 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(ARB_IDLE));
    idle();
    step();
    reset = 1'b0;

    // Lone fetch of 0x10: zero-wait grant, word 4.
    drv(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("f1_gnt", {31'd0, bus.f_gnt}, 32'd1);
    chk("f1_l_gnt", {31'd0, bus.l_gnt}, 32'd0);
    chk("f1_mem_en", {31'd0, bus.mem_en}, 32'd1);
    chk("f1_mem_addr", 32'(bus.mem_addr), 32'd4);
    chk("f1_mem_we", {31'd0, bus.mem_we}, 32'd0);
    push(1, 32'hC0DE_0004);
    step();
    idle();
    step();

    // Both requesting from reset: F,L,F,L,... and one stall per loader grant.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drv(1, 32'h20, 1, 0, 0, 32'h40, 0);
      #1;
      chk("rr_f_gnt", {31'd0, bus.f_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_l_gnt", {31'd0, bus.l_gnt}, (k % 2 == 0) ? 32'd0 : 32'd1);
      chk("rr_stall", bus.f_stall_cnt, 32'(k / 2));
      if (k % 2 == 0) push(1, 32'hC0DE_0008);
      else            push(0, 32'hC0DE_0010);
      step();
    end
    idle();
    step();

    // Locked loader burst writing 0x0..0xC; fetch held off until lock drops.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drv((k != 0), 32'h8, 1, (k < 3), 1, 32'(4 * k), 32'hDEAD_BEEF + 32'(k));
      #1;
      chk("lk_l_gnt", {31'd0, bus.l_gnt}, 32'd1);
      chk("lk_f_gnt", {31'd0, bus.f_gnt}, 32'd0);
      chk("lk_mem_we", {31'd0, bus.mem_we}, 32'd1);
      chk("lk_mem_addr", 32'(bus.mem_addr), 32'(k));
      chk("lk_wdata", bus.mem_wdata, 32'hDEAD_BEEF + 32'(k));
      step();
    end
    drv(1, 32'h8, 0, 0, 0, 0, 0);
    #1;
    chk("lk_f_after", {31'd0, bus.f_gnt}, 32'd1);
    chk("lk_stall", bus.f_stall_cnt, 32'd3);
    push(1, 32'hDEAD_BEF1);
    step();
    idle();
    step();

    // Address wrap: 0x1004 lands on word 1.
    drv(0, 0, 1, 0, 1, 32'h1004, 32'hA5A5_A5A5);
    #1;
    chk("wrap_l_gnt", {31'd0, bus.l_gnt}, 32'd1);
    chk("wrap_mem_addr", 32'(bus.mem_addr), 32'd1);
    chk("wrap_mem_we", {31'd0, bus.mem_we}, 32'd1);
    step();
    drv(1, 32'h4, 0, 0, 0, 0, 0);
    #1;
    chk("wrap_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
    chk("wrap_f_addr", 32'(bus.mem_addr), 32'd1);
    push(1, 32'hA5A5_A5A5);
    step();

    // Back-to-back loader reads, returns in order with no bubbles.
    for (int k = 0; k < 4; k++) begin
      drv(0, 0, 1, 0, 0, 32'(4 * k), 0);
      #1;
      chk("b2b_l_gnt", {31'd0, bus.l_gnt}, 32'd1);
      case (k)
        0: push(0, 32'hDEAD_BEEF);
        1: push(0, 32'hA5A5_A5A5);
        2: push(0, 32'hDEAD_BEF1);
        default: push(0, 32'hDEAD_BEF2);
      endcase
      step();
    end
    idle();
    step();

    // Reset right after a fetch grant cancels the return.
    drv(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("rc_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
    step();
    reset = 1'b1;
    drv(1, 32'h10, 1, 0, 0, 0, 0);
    #1;
    chk("rc_f_rvalid", {31'd0, bus.f_rvalid}, 32'd0);
    chk("rc_gnts", {30'd0, bus.f_gnt, bus.l_gnt}, 32'd0);
    chk("rc_mem_en", {31'd0, bus.mem_en}, 32'd0);
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("rc_f_rvalid2", {31'd0, bus.f_rvalid}, 32'd0);
    chk("rc_stall", bus.f_stall_cnt, 32'd0);
    chk("rc_state", 32'(dut.state_q), 32'(ARB_IDLE));
    step();

    // Reset while locked with a loader read outstanding.
    drv(0, 0, 1, 1, 0, 32'h0, 0);
    #1;
    chk("rl_l_gnt", {31'd0, bus.l_gnt}, 32'd1);
    step();
    chk("rl_state_locked", 32'(dut.state_q), 32'(ARB_LOCKED));
    reset = 1'b1;
    #1;
    chk("rl_l_rvalid", {31'd0, bus.l_rvalid}, 32'd0);
    step();
    reset = 1'b0;
    idle();
    #1;
    chk("rl_state", 32'(dut.state_q), 32'(ARB_IDLE));
    chk("rl_l_rvalid2", {31'd0, bus.l_rvalid}, 32'd0);
    step();
    drv(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("rl_f_gnt", {31'd0, bus.f_gnt}, 32'd1);
    push(1, 32'hC0DE_0004);
    step();

    // Stall counter saturation while the loader holds the lock.
    drv(0, 0, 1, 1, 1, 32'h100, 0);
    step();
    force dut.f_stall_cnt_q = 32'hFFFF_FFFE;
    drv(1, 32'h10, 1, 1, 1, 32'h100, 0);
    #1;
    chk("sat_pre", bus.f_stall_cnt, 32'hFFFF_FFFE);
    chk("sat_f_gnt", {31'd0, bus.f_gnt}, 32'd0);
    step();
    release dut.f_stall_cnt_q;
    step();
    #1;
    chk("sat_1", bus.f_stall_cnt, 32'hFFFF_FFFF);
    step();
    bus.l_lock = 1'b0;
    #1;
    chk("sat_2", bus.f_stall_cnt, 32'hFFFF_FFFF);
    chk("sat_f_gnt2", {31'd0, bus.f_gnt}, 32'd0);
    step();
    drv(1, 32'h10, 0, 0, 0, 0, 0);
    #1;
    chk("sat_3", bus.f_stall_cnt, 32'hFFFF_FFFF);
    chk("sat_f_after", {31'd0, bus.f_gnt}, 32'd1);
    push(1, 32'hC0DE_0004);
    step();
    idle();

    // Let outstanding returns drain.
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) step();
    step();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d pending returns expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
